// File: rtl/modmul_arbiter_pkg.sv
// Shared definitions for the modular-multiplier front-end arbiter:
// operand width, default multiplier latency and requester-id sizing.
package modmul_arbiter_pkg;

    localparam int OPW     = 256;
    localparam int DEF_LAT = 24;

    // Bits needed to hold a requester index; a single bit is the minimum.
    function automatic int id_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/modmul_arbiter_rr.sv
// Round-robin grant picker: the first asserted request at or after i_ptr
// (wrapping) wins. Purely combinational; the caller owns the pointer.
module rr_arbiter
    import modmul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
)(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_gnt_valid
);

    logic [IDW-1:0] w_idx;

    // Scan from the pointer upward and keep only the first eligible request.
    always_comb begin
        o_gnt       = '0;
        o_gnt_id    = '0;
        o_gnt_valid = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid  = 1'b1;
                o_gnt_id     = w_idx;
                o_gnt[w_idx] = 1'b1;
            end else begin
                o_gnt_valid  = o_gnt_valid;
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Shares one pipelined modular multiplier among NREQ requesters. Operations
// are granted round-robin, tagged with the requester id through a delay line
// that matches the multiplier latency, and results are routed back by tag.
module modmul_arbiter
    import modmul_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int LAT    = DEF_LAT,
    parameter int MAXOUT = 8
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_x,
    input  logic [NREQ*OPW-1:0] req_y,
    output logic                mm_in_valid,
    output logic [OPW-1:0]      mm_x,
    output logic [OPW-1:0]      mm_y,
    input  logic                mm_out_valid,
    input  logic [OPW-1:0]      mm_q,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [OPW-1:0]      rsp_q,
    output logic                busy,
    output logic                err
);

    localparam int IDW   = id_width(NREQ);
    localparam int CW    = $clog2(MAXOUT + 1);
    // After a reset the multiplier may still deliver results for operations
    // whose tags were wiped; ignore untagged results for this many cycles.
    localparam int DRAIN = LAT + 1;
    localparam int DW    = $clog2(DRAIN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXOUT);

    logic [CW-1:0]   r_count [NREQ];
    logic [IDW-1:0]  r_rr_ptr;
    logic            r_mm_in_valid;
    logic [OPW-1:0]  r_mm_x;
    logic [OPW-1:0]  r_mm_y;
    logic [IDW-1:0]  r_issue_id;
    logic [LAT-1:0]  r_tag_v;
    logic [IDW-1:0]  r_tag_id [LAT];
    logic [NREQ-1:0] r_rsp_valid;
    logic [OPW-1:0]  r_rsp_q;
    logic            r_err;
    logic [DW-1:0]   r_drain;

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_gnt_valid;
    logic            w_accept;
    logic            w_tag_v;
    logic [IDW-1:0]  w_tag_id;
    logic            w_retire;
    logic            w_mismatch;
    logic            w_busy;

    // A requester competes only while it is asking and below its in-flight cap.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = req_valid[i] && (r_count[i] != CNT_MAX);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req       (w_eligible),
        .i_ptr       (r_rr_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    assign req_ready = reset ? w_gnt : '0;
    assign w_accept  = w_gnt_valid & reset;

    assign w_tag_v    = r_tag_v[LAT-1];
    assign w_tag_id   = r_tag_id[LAT-1];
    assign w_retire   = w_tag_v & mm_out_valid;
    assign w_mismatch = (w_tag_v != mm_out_valid) && !((r_drain != '0) && !w_tag_v);

    // Round-robin pointer: next search begins just after the last grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Issue register: capture the granted operands; operands hold when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mm_in_valid <= 1'b0;
            r_mm_x        <= '0;
            r_mm_y        <= '0;
            r_issue_id    <= '0;
        end else begin
            r_mm_in_valid <= w_accept;
            if (w_accept) begin
                r_mm_x     <= req_x[w_gnt_id*OPW +: OPW];
                r_mm_y     <= req_y[w_gnt_id*OPW +: OPW];
                r_issue_id <= w_gnt_id;
            end else begin
                r_issue_id <= r_issue_id;
            end
        end
    end

    // Tag delay line fed by the issue register; its last stage lines up with
    // the multiplier output for the same operation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_mm_in_valid;
            r_tag_id[0] <= r_issue_id;
            for (int k = 1; k < LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Result routing, sticky tag/result mismatch flag and post-reset drain timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_err       <= 1'b0;
            r_drain     <= DW'(DRAIN);
        end else begin
            r_rsp_valid <= '0;
            if (w_retire) begin
                r_rsp_valid[w_tag_id] <= 1'b1;
                r_rsp_q               <= mm_q;
            end else begin
                r_rsp_q <= r_rsp_q;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
            if (r_drain != '0) begin
                r_drain <= r_drain - DW'(1);
            end else begin
                r_drain <= r_drain;
            end
        end
    end

    // Per-requester in-flight counters; accept and retire together cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_accept && (w_gnt_id == IDW'(i)),
                       w_retire && (w_tag_id == IDW'(i)) && (r_count[i] != '0)})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Busy while any requester still has an operation outstanding.
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_count[i] != '0) begin
                w_busy = 1'b1;
            end else begin
                w_busy = w_busy;
            end
        end
    end

    assign mm_in_valid = r_mm_in_valid;
    assign mm_x        = r_mm_x;
    assign mm_y        = r_mm_y;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_q       = r_rsp_q;
    assign err         = r_err;
    assign busy        = w_busy;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a fixed-latency model multiplier.
module tb_modmul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 24;
    localparam int MAXO = 8;
    localparam int W    = 256;

    logic            clock;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic            mm_in_valid;
    logic [W-1:0]    mm_x;
    logic [W-1:0]    mm_y;
    logic            mm_out_valid;
    logic [W-1:0]    mm_q;
    logic [NREQ-1:0] rsp_valid;
    logic [W-1:0]    rsp_q;
    logic            busy;
    logic            err;

    logic [LAT-1:0]  mdl_v = '0;
    logic [W-1:0]    mdl_q [LAT];
    logic            inj;

    int n_pass  = 0;
    int n_total = 0;

    modmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXO)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .mm_in_valid  (mm_in_valid),
        .mm_x         (mm_x),
        .mm_y         (mm_y),
        .mm_out_valid (mm_out_valid),
        .mm_q         (mm_q),
        .rsp_valid    (rsp_valid),
        .rsp_q        (rsp_q),
        .busy         (busy),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model multiplier: fixed LAT-cycle pipeline, never reset.
    always @(posedge clock) begin
        mdl_v[0] <= mm_in_valid;
        mdl_q[0] <= mm_x * mm_y;
        for (int k = 1; k < LAT; k++) begin
            mdl_v[k] <= mdl_v[k-1];
            mdl_q[k] <= mdl_q[k-1];
        end
    end
    assign mm_out_valid = mdl_v[LAT-1] | inj;
    assign mm_q         = mdl_q[LAT-1];

    task automatic drive_pt();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) drive_pt();
    endtask

    task automatic do_reset();
        drive_pt();
        reset = 1'b0;
        drive_pt();
        reset = 1'b1;
        wait_cycles(30);
    endtask

    task automatic test_reset();
        reset = 1'b1; inj = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
        #2;
        reset = 1'b0;
        req_valid = 4'b1111;
        @(negedge clock);
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else n_pass++;
        n_total++; if (mm_in_valid !== 1'b0) $display("FAIL reset_mm_in_valid: got %b expected 0", mm_in_valid); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        n_total++; if (mm_x !== 256'd0) $display("FAIL reset_mm_x: got %0h expected 0", mm_x); else n_pass++;
        n_total++; if (rsp_q !== 256'd0) $display("FAIL reset_rsp_q: got %0h expected 0", rsp_q); else n_pass++;
        req_valid = '0;
        drive_pt();
        reset = 1'b1;
        wait_cycles(30);
    endtask

    task automatic test_single();
        int lat;
        lat = -1;
        req_x[2*W +: W] = 256'd3;
        req_y[2*W +: W] = 256'd5;
        req_valid = 4'b0100;
        @(negedge clock);
        n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready); else n_pass++;
        drive_pt();
        req_valid = '0;
        @(negedge clock);
        n_total++; if (mm_in_valid !== 1'b1) $display("FAIL single_mm_in_valid: got %b expected 1", mm_in_valid); else n_pass++;
        n_total++; if (mm_x !== 256'd3 || mm_y !== 256'd5) $display("FAIL single_operands: got %0h,%0h expected 3,5", mm_x, mm_y); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        for (int k = 2; k <= 40 && lat < 0; k++) begin
            drive_pt();
            @(negedge clock);
            if (rsp_valid !== 4'b0000) lat = k;
        end
        n_total++; if (lat != 26) $display("FAIL single_latency: got %0d expected 26", lat); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); else n_pass++;
        n_total++; if (rsp_q !== 256'd15) $display("FAIL single_rsp_q: got %0h expected f", rsp_q); else n_pass++;
        drive_pt();
        @(negedge clock);
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_clear: got %b expected 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_q !== 256'd15) $display("FAIL single_rsp_q_hold: got %0h expected f", rsp_q); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (mm_in_valid !== 1'b0 || mm_x !== 256'd3) $display("FAIL single_idle_hold: got %b,%0h expected 0,3", mm_in_valid, mm_x); else n_pass++;
        drive_pt();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] seen_v [8];
        logic [W-1:0]    seen_q [8];
        logic [NREQ-1:0] exp_v;
        logic [W-1:0]    exp_q;
        int got;
        got = 0;
        for (int j = 0; j < 8; j++) begin seen_v[j] = '0; seen_q[j] = '0; end
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = 256'(10 + i);
            req_y[i*W +: W] = 256'd2;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_v = 4'b0001 << (c % 4);
            @(negedge clock);
            n_total++; if (req_ready !== exp_v) $display("FAIL rr_grant_%0d: got %b expected %b", c, req_ready, exp_v); else n_pass++;
            drive_pt();
        end
        req_valid = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clock);
            if (rsp_valid !== 4'b0000) begin
                seen_v[got] = rsp_valid;
                seen_q[got] = rsp_q;
                got++;
            end
            drive_pt();
        end
        n_total++; if (got != 8) $display("FAIL rr_rsp_count: got %0d expected 8", got); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            exp_v = 4'b0001 << (j % 4);
            exp_q = 256'(20 + 2 * (j % 4));
            n_total++; if (seen_v[j] !== exp_v || seen_q[j] !== exp_q) $display("FAIL rr_rsp_%0d: got %b/%0h expected %b/%0h", j, seen_v[j], seen_q[j], exp_v, exp_q); else n_pass++;
        end
        wait_cycles(5);
    endtask

    task automatic test_outstanding();
        int acc_early, acc_blocked, rsp_more;
        acc_early = 0; acc_blocked = 0; rsp_more = 0;
        req_x[0 +: W] = 256'd7;
        req_y[0 +: W] = 256'd6;
        req_valid = 4'b0001;
        for (int c = 0; c < 26; c++) begin
            @(negedge clock);
            if (req_ready[0] === 1'b1) begin
                if (c < 8) acc_early++; else acc_blocked++;
            end
            drive_pt();
        end
        @(negedge clock);
        n_total++; if (acc_early != 8) $display("FAIL lim_first_accepts: got %0d expected 8", acc_early); else n_pass++;
        n_total++; if (acc_blocked != 0) $display("FAIL lim_blocked: got %0d expected 0", acc_blocked); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0001 || rsp_q !== 256'd42) $display("FAIL lim_first_rsp: got %b/%0h expected 0001/2a", rsp_valid, rsp_q); else n_pass++;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL lim_reaccept: got %b expected 0001", req_ready); else n_pass++;
        drive_pt();
        req_valid = '0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clock);
            if (rsp_valid === 4'b0001) rsp_more++;
            drive_pt();
        end
        n_total++; if (rsp_more != 8) $display("FAIL lim_rest_rsp: got %0d expected 8", rsp_more); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL lim_busy_end: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_simul();
        req_x[1*W +: W] = 256'd2;
        req_y[1*W +: W] = 256'd9;
        req_valid = 4'b0010;
        wait_cycles(3);
        req_valid = '0;
        for (int c = 3; c < 24; c++) drive_pt();
        @(negedge clock);
        n_total++; if (dut.r_count[1] !== 4'd3) $display("FAIL simul_count_before: got %0d expected 3", dut.r_count[1]); else n_pass++;
        drive_pt();
        req_valid = 4'b0010;
        @(negedge clock);
        n_total++; if (req_ready !== 4'b0010) $display("FAIL simul_accept: got %b expected 0010", req_ready); else n_pass++;
        drive_pt();
        req_valid = '0;
        @(negedge clock);
        n_total++; if (rsp_valid !== 4'b0010 || rsp_q !== 256'd18) $display("FAIL simul_rsp: got %b/%0h expected 0010/12", rsp_valid, rsp_q); else n_pass++;
        n_total++; if (dut.r_count[1] !== 4'd3) $display("FAIL simul_count_after: got %0d expected 3", dut.r_count[1]); else n_pass++;
        wait_cycles(40);
        n_total++; if (busy !== 1'b0) $display("FAIL simul_busy_end: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_err();
        @(negedge clock);
        n_total++; if (err !== 1'b0) $display("FAIL err_before: got %b expected 0", err); else n_pass++;
        drive_pt();
        inj = 1'b1;
        drive_pt();
        inj = 1'b0;
        @(negedge clock);
        n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL err_no_rsp: got %b expected 0000", rsp_valid); else n_pass++;
        wait_cycles(5);
        @(negedge clock);
        n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err); else n_pass++;
        drive_pt();
    endtask

    task automatic test_reset_mid();
        int seen_rsp, seen_err;
        seen_rsp = 0; seen_err = 0;
        do_reset();
        n_total++; if (err !== 1'b0) $display("FAIL mid_err_cleared: got %b expected 0", err); else n_pass++;
        req_valid = 4'b1111;
        wait_cycles(5);
        req_valid = '0;
        wait_cycles(3);
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy_reset: got %b expected 0", busy); else n_pass++;
        drive_pt();
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rsp_valid !== 4'b0000) seen_rsp++;
            if (err !== 1'b0) seen_err++;
            drive_pt();
        end
        n_total++; if (seen_rsp != 0) $display("FAIL mid_no_rsp: got %0d expected 0", seen_rsp); else n_pass++;
        n_total++; if (seen_err != 0) $display("FAIL mid_no_err: got %0d expected 0", seen_err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy_end: got %b expected 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_outstanding();
        test_simul();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
